// File: rtl/status_flag_unit.sv
// NZCV status register with in-flight flag tracking, hazard and shadow copy.
// Optional macro FLAG_BYPASS_EN: forward the youngest pending flags instead of a hazard.
module status_flag_unit #(
   parameter int COMMIT_LAT = 1,
   parameter int FLAG_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              id_s_bit,
   input  logic              id_cond_used,
   input  logic              freeze,
   input  logic              flush,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic              save_req,
   input  logic              restore_req,
   output logic [FLAG_W-1:0] status_register,
   output logic              flag_hazard,
   output logic [FLAG_W-1:0] shadow_flags,
   output logic [2:0]        pending_cnt
);

   logic [FLAG_W-1:0]     sr_q;
   logic [FLAG_W-1:0]     shadow_q;
   logic [COMMIT_LAT-1:0] valid_q;
   logic [FLAG_W-1:0]     slot_val [COMMIT_LAT];
   logic                  load0;
   logic                  commit;
   logic [FLAG_W-1:0]     commit_val;

   assign load0       = id_valid & id_s_bit & ~freeze & ~flush;
   assign slot_val[0] = alu_flags;

   // Valid bits: slot 0 loads from ID, older slots shift unconditionally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= load0;
         for (int k = 1; k < COMMIT_LAT; k++) begin
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   generate
      if (COMMIT_LAT > 1) begin : g_vals
         logic [FLAG_W-1:0] val_q [1:COMMIT_LAT-1];

         // Flag values follow their valid bits; slot 1 captures live ALU flags
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 1; k < COMMIT_LAT; k++) begin
                  val_q[k] <= '0;
               end
            end else begin
               for (int k = 1; k < COMMIT_LAT; k++) begin
                  val_q[k] <= (k == 1) ? alu_flags : val_q[k-1];
               end
            end
         end

         for (genvar k = 1; k < COMMIT_LAT; k++) begin : g_out
            assign slot_val[k] = val_q[k];
         end
      end
   endgenerate

   assign commit     = valid_q[COMMIT_LAT-1];
   assign commit_val = slot_val[COMMIT_LAT-1];

   // Status register: restore beats commit, a dropped commit is lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else if (restore_req) begin
         sr_q <= shadow_q;
      end else if (commit) begin
         sr_q <= commit_val;
      end
   end

   // Shadow copy takes the pre-commit SR; with restore this forms a swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (save_req) begin
         shadow_q <= sr_q;
      end
   end

   // Count of in-flight flag writes
   always_comb begin
      pending_cnt = '0;
      for (int k = 0; k < COMMIT_LAT; k++) begin
         pending_cnt = pending_cnt + {2'b00, valid_q[k]};
      end
   end

   assign shadow_flags = shadow_q;

`ifdef FLAG_BYPASS_EN
   // Forward the youngest pending value; slot 0 is the youngest
   always_comb begin
      status_register = sr_q;
      for (int k = COMMIT_LAT - 1; k >= 0; k--) begin
         if (valid_q[k]) begin
            status_register = slot_val[k];
         end
      end
   end

   assign flag_hazard = 1'b0;
`else
   // No forwarding: consumers stall while any flag write is in flight
   always_comb begin
      status_register = sr_q;
      flag_hazard     = id_valid & id_cond_used & (pending_cnt != 3'd0);
   end
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit at COMMIT_LAT=1 and COMMIT_LAT=3.
// Expectations switch on FLAG_BYPASS_EN where forwarding changes them.
module tb_status_flag_unit;

`ifdef FLAG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       a_vld = 0, a_s = 0, a_cu = 0, a_frz = 0, a_fl = 0;
   logic       a_sv = 0, a_rs = 0;
   logic [3:0] a_alu = 0;
   logic [3:0] a_sr, a_sh;
   logic       a_hz;
   logic [2:0] a_cnt;

   logic       b_vld = 0, b_s = 0, b_cu = 0, b_frz = 0, b_fl = 0;
   logic       b_sv = 0, b_rs = 0;
   logic [3:0] b_alu = 0;
   logic [3:0] b_sr, b_sh;
   logic       b_hz;
   logic [2:0] b_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   status_flag_unit #(.COMMIT_LAT(1), .FLAG_W(4)) u1 (
      .clk(clk), .rst_n(rst_n),
      .id_valid(a_vld), .id_s_bit(a_s), .id_cond_used(a_cu),
      .freeze(a_frz), .flush(a_fl), .alu_flags(a_alu),
      .save_req(a_sv), .restore_req(a_rs),
      .status_register(a_sr), .flag_hazard(a_hz),
      .shadow_flags(a_sh), .pending_cnt(a_cnt)
   );

   status_flag_unit #(.COMMIT_LAT(3), .FLAG_W(4)) u3 (
      .clk(clk), .rst_n(rst_n),
      .id_valid(b_vld), .id_s_bit(b_s), .id_cond_used(b_cu),
      .freeze(b_frz), .flush(b_fl), .alu_flags(b_alu),
      .save_req(b_sv), .restore_req(b_rs),
      .status_register(b_sr), .flag_hazard(b_hz),
      .shadow_flags(b_sh), .pending_cnt(b_cnt)
   );

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic commit_a(input logic [3:0] v);
      a_vld = 1; a_s = 1;
      tick();
      a_vld = 0; a_s = 0; a_alu = v;
      tick();
      a_alu = 4'b0000;
      #1;
   endtask

   initial begin
      // reset
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_sr_a", a_sr, 4'b0000);
      chk("rst_sh_a", a_sh, 4'b0000);
      chk("rst_cnt_b", {1'b0, b_cnt}, 4'd0);
      chk("rst_sh_b", b_sh, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_sr", a_sr, 4'b0000);
         chk("idle_cnt", {1'b0, a_cnt}, 4'd0);
         chk("idle_hz", {3'b0, a_hz}, 4'd0);
      end

      // COMMIT_LAT=1: hazard / forward between EXE and commit
      a_vld = 1; a_s = 1;
      tick();
      a_s = 0; a_cu = 1; a_alu = 4'b1000;
      #1;
      chk("l1_cnt", {1'b0, a_cnt}, 4'd1);
      chk("l1_hz", {3'b0, a_hz}, BYP ? 4'd0 : 4'd1);
      chk("l1_sr_mid", a_sr, BYP ? 4'b1000 : 4'b0000);
      tick();
      a_vld = 0; a_cu = 0; a_alu = 4'b0000;
      #1;
      chk("l1_sr", a_sr, 4'b1000);
      chk("l1_cnt0", {1'b0, a_cnt}, 4'd0);
      chk("l1_hz0", {3'b0, a_hz}, 4'd0);

      // freeze / flush kill slot-0 loading
      a_vld = 1; a_s = 1; a_frz = 1; a_alu = 4'b0101;
      tick();
      chk("frz_cnt", {1'b0, a_cnt}, 4'd0);
      a_frz = 0; a_fl = 1;
      tick();
      chk("fl_cnt", {1'b0, a_cnt}, 4'd0);
      a_frz = 1;
      tick();
      chk("frzfl_cnt", {1'b0, a_cnt}, 4'd0);
      a_vld = 0; a_s = 0; a_frz = 0; a_fl = 0;
      tick();
      chk("frz_sr", a_sr, 4'b1000);

      // save, then restore colliding with a commit
      commit_a(4'b1010);
      chk("sv_pre_sr", a_sr, 4'b1010);
      a_sv = 1;
      tick();
      a_sv = 0;
      #1;
      chk("sv_sh", a_sh, 4'b1010);
      commit_a(4'b0110);
      chk("sv_sr2", a_sr, 4'b0110);
      a_vld = 1; a_s = 1;
      tick();
      a_vld = 0; a_s = 0; a_alu = 4'b0001; a_rs = 1;
      #1;
      chk("rs_cnt", {1'b0, a_cnt}, 4'd1);
      tick();
      a_rs = 0; a_alu = 4'b0000;
      #1;
      chk("rs_sr", a_sr, 4'b1010);
      chk("rs_cnt0", {1'b0, a_cnt}, 4'd0);

      // swap
      commit_a(4'b1100);
      a_sv = 1;
      tick();
      a_sv = 0;
      #1;
      commit_a(4'b0011);
      chk("sw_pre_sr", a_sr, 4'b0011);
      chk("sw_pre_sh", a_sh, 4'b1100);
      a_sv = 1; a_rs = 1;
      tick();
      a_sv = 0; a_rs = 0;
      #1;
      chk("sw_sr", a_sr, 4'b1100);
      chk("sw_sh", a_sh, 4'b0011);

      // COMMIT_LAT=3: back-to-back S instructions
      b_vld = 1; b_s = 1;
      tick();
      chk("l3_cnt1", {1'b0, b_cnt}, 4'd1);
      b_alu = 4'b0100;
      tick();
      chk("l3_cnt2", {1'b0, b_cnt}, 4'd2);
      b_vld = 0; b_s = 0; b_alu = 4'b0010;
      tick();
      b_alu = 4'b0000;
      b_vld = 1; b_cu = 1;
      #1;
      chk("l3_cnt3", {1'b0, b_cnt}, 4'd2);
      chk("l3_hz", {3'b0, b_hz}, BYP ? 4'd0 : 4'd1);
      chk("l3_sr3", b_sr, BYP ? 4'b0010 : 4'b0000);
      tick();
      b_vld = 0; b_cu = 0;
      #1;
      chk("l3_cnt4", {1'b0, b_cnt}, 4'd1);
      chk("l3_sr4", b_sr, BYP ? 4'b0010 : 4'b0100);
      tick();
      chk("l3_cnt5", {1'b0, b_cnt}, 4'd0);
      chk("l3_sr5", b_sr, 4'b0010);
      chk("l3_hz5", {3'b0, b_hz}, 4'd0);

      // reset with two writes pending
      b_vld = 1; b_s = 1;
      tick();
      b_alu = 4'b1111;
      tick();
      b_vld = 0; b_s = 0; b_alu = 4'b0110;
      #1;
      chk("mr_cnt_pre", {1'b0, b_cnt}, 4'd2);
      rst_n = 1'b0;
      #1;
      chk("mr_cnt", {1'b0, b_cnt}, 4'd0);
      chk("mr_sr", b_sr, 4'b0000);
      tick();
      rst_n = 1'b1;
      b_alu = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_post_sr", b_sr, 4'b0000);
         chk("mr_post_cnt", {1'b0, b_cnt}, 4'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
